// File: rtl/uart_receiver_of_verifla.sv
// 8N1 UART receive front end for the analyzer host link.
// Ports: clk, reset (async, high), rxd in; rec_dataH, rec_readyH, frame_error out.
// Optional VERIFLA_RX_MAJORITY_EN: 2-of-3 majority sampling, decisions one clock later.
module uart_receiver_of_verifla #(
  parameter int unsigned BAUD_DIVISOR = 868,
  parameter int unsigned DIV_BITS     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rec_dataH,
  output logic       rec_readyH,
  output logic       frame_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic [DIV_BITS-1:0] LAST =
    DIV_BITS'(BAUD_DIVISOR - 1);

`ifdef VERIFLA_RX_MAJORITY_EN
  // Start decision one clock past mid-bit; the
  // data/stop points inherit that one-clock shift.
  localparam logic [DIV_BITS-1:0] START_PT =
    DIV_BITS'(BAUD_DIVISOR / 2);
`else
  localparam logic [DIV_BITS-1:0] START_PT =
    DIV_BITS'(BAUD_DIVISOR / 2 - 1);
`endif

  logic [1:0]          sync_q;
  logic                rxs;
  logic                bit_s;
  state_e              state_q, state_d;
  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          data_q, data_d;
  logic                rdy_q, rdy_d;
  logic                ferr_q, ferr_d;
  logic                at_start, at_last;

  assign rxs = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rxd};
  end

`ifdef VERIFLA_RX_MAJORITY_EN
  // hist_q holds rxs from the two previous clocks,
  // so with rxs it spans nominal-1 .. nominal+1.
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= 2'b11;
    else       hist_q <= {hist_q[0], rxs};
  end

  assign bit_s = (hist_q[1] & hist_q[0]) |
                 (hist_q[1] & rxs) |
                 (hist_q[0] & rxs);
`else
  assign bit_s = rxs;
`endif

  assign at_start = (cnt_q == START_PT);
  assign at_last  = (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!rxs) state_d = START;
      START: if (at_start)
               state_d = bit_s ? IDLE : DATA;
      DATA:  if (at_last && idx_q == 3'd7)
               state_d = STOP;
      STOP:  if (at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + DIV_BITS'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    ferr_d  = ferr_q;
    case (state_q)
      IDLE: cnt_d = '0;
      START: begin
        if (at_start) begin
          cnt_d = '0;
          // A high sample is a glitch: outputs untouched.
          if (!bit_s) begin
            rdy_d  = 1'b0;
            ferr_d = 1'b0;
            idx_d  = 3'd0;
          end
        end
      end
      DATA: begin
        if (at_last) begin
          cnt_d   = '0;
          shift_d = {bit_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (at_last) begin
          cnt_d = '0;
          if (bit_s) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rec_dataH   = data_q;
  assign rec_readyH  = rdy_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_uart_receiver_of_verifla.sv
// Directed bench for uart_receiver_of_verifla, BAUD_DIVISOR=16.
// Cycle offsets are counted from the edge after which rxd first falls.
module tb_uart_receiver_of_verifla;

`ifdef VERIFLA_RX_MAJORITY_EN
  localparam int M = 1;
  localparam logic [7:0] GLITCH_BYTE = 8'h00;
`else
  localparam int M = 0;
  localparam logic [7:0] GLITCH_BYTE = 8'h08;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rec_dataH;
  logic       rec_readyH;
  logic       frame_error;

  uart_receiver_of_verifla #(
    .BAUD_DIVISOR(16),
    .DIV_BITS(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rxd(rxd),
    .rec_dataH(rec_dataH),
    .rec_readyH(rec_readyH),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         start_cyc = 0;
  int         rise_cyc = 0;
  int         fall_cyc = 0;
  logic       rdy_prev = 1'b0;
  logic [7:0] data_at_fall = 8'h00;

  always @(negedge clk) begin
    if (rec_readyH && !rdy_prev) rise_cyc = cyc;
    if (!rec_readyH && rdy_prev) begin
      fall_cyc = cyc;
      data_at_fall = rec_dataH;
    end
    rdy_prev = rec_readyH;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Each bit is held for exactly 16 clock edges.
  task automatic send_frame(input logic [7:0] b,
                            input logic stop);
    @(posedge clk);
    #1 rxd = 1'b0;
    start_cyc = cyc;
    repeat (15) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 rxd = b[i];
      repeat (15) @(posedge clk);
    end
    @(posedge clk);
    #1 rxd = stop;
    repeat (15) @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 rxd = 1'b1;
    repeat (n - 1) @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(rec_dataH), 32'h00);
    check("rst_ready", 32'(rec_readyH), 32'h0);
    check("rst_ferr", 32'(frame_error), 32'h0);
    #2 reset = 1'b0;
    idle(5);

    // First byte; t0 = start+3, stop sampled at t0+152.
    send_frame(8'h01, 1'b1);
    check("b01_data", 32'(rec_dataH), 32'h01);
    check("b01_ready", 32'(rec_readyH), 32'h1);
    check("b01_ferr", 32'(frame_error), 32'h0);
    check("b01_rise", 32'(rise_cyc - start_cyc),
          32'(155 + M));
    idle(10);

    // Back-to-back 0x00 then 0xA5.
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hA5, 1'b1);
      end
      begin
        repeat (158) @(posedge clk);
        #1;
        check("b2b_first_ready", 32'(rec_readyH), 32'h1);
        check("b2b_first_data", 32'(rec_dataH), 32'h00);
      end
    join
    check("b2b_fall", 32'(fall_cyc - start_cyc),
          32'(11 + M));
    check("b2b_hold", 32'(data_at_fall), 32'h00);
    check("b2b_data", 32'(rec_dataH), 32'hA5);
    check("b2b_ready", 32'(rec_readyH), 32'h1);
    idle(10);

    // Four-clock start glitch: nothing changes.
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("glitch_ready", 32'(rec_readyH), 32'h1);
    check("glitch_data", 32'(rec_dataH), 32'hA5);
    check("glitch_ferr", 32'(frame_error), 32'h0);
    idle(5);

    // Bad stop bit, then idle high.
    send_frame(8'h5A, 1'b0);
    idle(30);
    check("bad_ferr", 32'(frame_error), 32'h1);
    check("bad_ready", 32'(rec_readyH), 32'h0);
    check("bad_data", 32'(rec_dataH), 32'hA5);
    send_frame(8'hC3, 1'b1);
    check("recov_ferr", 32'(frame_error), 32'h0);
    check("recov_ready", 32'(rec_readyH), 32'h1);
    check("recov_data", 32'(rec_dataH), 32'hC3);
    idle(10);

    // Reset during bit 4 of 0xFF.
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (87) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_data", 32'(rec_dataH), 32'h00);
        check("mid_rst_ready", 32'(rec_readyH), 32'h0);
        check("mid_rst_ferr", 32'(frame_error), 32'h0);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
      end
    join
    idle(10);
    send_frame(8'h3C, 1'b1);
    check("post_rst_data", 32'(rec_dataH), 32'h3C);
    check("post_rst_ready", 32'(rec_readyH), 32'h1);
    check("post_rst_ferr", 32'(frame_error), 32'h0);
    idle(10);

    // One-clock high glitch at the bit-3 sample point.
    fork
      send_frame(8'h00, 1'b1);
      begin
        repeat (73) @(posedge clk);
        #2 rxd = 1'b1;
        @(posedge clk);
        #2 rxd = 1'b0;
      end
    join
    check("dglitch_data", 32'(rec_dataH),
          32'(GLITCH_BYTE));
    check("dglitch_ready", 32'(rec_readyH), 32'h1);
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
